// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST pattern controller.
//   - bist_state_e : controller FSM states (IDLE / APPLY / DONE)
//   - MODE_EXH / MODE_LFSR : pattern-source selector values
//   - MISR_POLY_DEF : default 16-bit MISR feedback polynomial
//   - lfsr_taps()   : maximal-length Fibonacci tap mask for widths 1..16
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } bist_state_e;

  localparam logic MODE_EXH  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [15:0] MISR_POLY_DEF = 16'h1021;

  // Tap mask for a shift-left Fibonacci LFSR whose feedback bit is the XOR of
  // (state & mask). Bit (t-1) is set for each polynomial term x^t.
  function automatic logic [15:0] lfsr_taps(input int unsigned n);
    logic [15:0] m;
    case (n)
      1:       m = 16'h0001;
      2:       m = 16'h0003;
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the signature
//   clr   : synchronous clear (start of a run)
//   en    : fold d into the signature at this edge
//   d     : N_OUT-bit response, zero-extended to SIG_W before folding
//   sig   : current signature
module bist_misr
  import bist_pkg::*;
#(
  parameter int                SIG_W     = 16,
  parameter int                N_OUT     = 2,
  parameter logic [SIG_W-1:0]  MISR_POLY = SIG_W'(MISR_POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [N_OUT-1:0] d,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] nxt;

  // Galois-style shift: the bit shifted out of the top decides whether the
  // polynomial is folded back in; the response is XORed on top.
  always_comb begin
    nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   sig <= '0;
    else if (clr) sig <= '0;
    else if (en)  sig <= nxt;
  end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// bist_pattern_ctrl: stimulus/response engine for small combinational
// netlists. A start pulse in IDLE launches a run that applies either every
// N_IN-bit vector (exhaustive counter) or the 2^N_IN-1 nonzero vectors of a
// maximal LFSR, holding each for HOLD_CYCLES clocks and compacting dut_out
// into a MISR on the last clock of each hold.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin a run (honoured only in IDLE)
//   mode        : 0 = exhaustive, 1 = LFSR; latched with start
//   dut_in      : vector driven to the DUT
//   dut_out     : DUT response (combinational from dut_in)
//   busy        : high while vectors are applied
//   done        : one-cycle pulse after the last vector
//   vec_idx     : vectors fully applied in this run
//   signature   : MISR contents, held until the next start
//
// Optional build macro BIST_GOLDEN_CMP_EN adds:
//   golden      : expected signature
//   pass        : signature == golden, evaluated during the done cycle
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int               N_IN        = 5,
  parameter int               N_OUT       = 2,
  parameter int               HOLD_CYCLES = 2,
  parameter int               SIG_W       = 16,
  parameter logic [SIG_W-1:0] MISR_POLY   = SIG_W'(MISR_POLY_DEF),
  parameter logic [N_IN-1:0]  LFSR_TAPS   = N_IN'(lfsr_taps(N_IN))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    vec_idx,
`ifdef BIST_GOLDEN_CMP_EN
  input  logic [SIG_W-1:0] golden,
  output logic             pass,
`endif
  output logic [SIG_W-1:0] signature
);

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  // vec_idx value *before* the increment on the final capture edge
  localparam logic [N_IN:0] LAST_EXH  = (N_IN+1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0] LAST_LFSR = (N_IN+1)'((1 << N_IN) - 2);

  bist_state_e       state, state_nxt;
  logic              mode_q;
  logic [HW-1:0]     hold;
  logic              go, capture, last;
  logic [N_IN-1:0]   lfsr_nxt;
  logic              fb;

  assign go      = (state == IDLE) && start;
  assign capture = (state == APPLY) && (hold == HOLD_LAST);
  assign last    = capture && (vec_idx == ((mode_q == MODE_LFSR) ? LAST_LFSR : LAST_EXH));

  // Shift left, feedback into bit 0. Truncating the concatenation keeps this
  // legal for N_IN == 1 where there is no dut_in[N_IN-2:0].
  assign fb       = ^(dut_in & LFSR_TAPS);
  assign lfsr_nxt = N_IN'({dut_in, fb});

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state == APPLY);
    done = (state == DONE);
  end

  // ---- pattern source, hold counter, vector index ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_in  <= '0;
      vec_idx <= '0;
      hold    <= '0;
      mode_q  <= MODE_EXH;
    end else if (go) begin
      mode_q  <= mode;
      vec_idx <= '0;
      hold    <= '0;
      dut_in  <= (mode == MODE_LFSR) ? N_IN'(1) : '0;
    end else if (state == APPLY) begin
      if (capture) begin
        hold    <= '0;
        vec_idx <= vec_idx + (N_IN+1)'(1);
        if (last)                    dut_in <= '0;
        else if (mode_q == MODE_LFSR) dut_in <= lfsr_nxt;
        else                         dut_in <= dut_in + N_IN'(1);
      end else begin
        hold <= hold + HW'(1);
      end
    end
  end

  bist_misr #(
    .SIG_W    (SIG_W),
    .N_OUT    (N_OUT),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (capture),
    .d    (dut_out),
    .sig  (signature)
  );

`ifdef BIST_GOLDEN_CMP_EN
  // The final signature is only stable once DONE is entered, so the compare
  // is taken at the edge closing the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)             pass <= 1'b0;
    else if (go)            pass <= 1'b0;
    else if (state == DONE) pass <= (signature == golden);
  end
`endif

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
module tb_bist_pattern_ctrl;
  localparam int N_IN = 5;
  localparam int N_OUT = 2;
  localparam int H = 2;
  localparam int NV = 1 << N_IN;
  localparam int TAPS = 5'b10100;
  localparam int POLY = 16'h1021;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [N_IN-1:0] dut_in;
  logic [N_OUT-1:0] dut_out;
  logic busy, done;
  logic [N_IN:0] vec_idx;
  logic [15:0] signature;
`ifdef BIST_GOLDEN_CMP_EN
  logic [15:0] golden = '0;
  logic pass;
`endif

  int n_cmp = 0, n_err = 0;
  int rsel = 0;          // 0: tied 0, 1: c17, 2: random lookup table
  logic fault = 1'b0;    // c17 N22 stuck-at-0
  logic [1:0] lut [NV];
  int vecs[$];
  int obs[$];

  always #5 clk = ~clk;

  bist_pattern_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .vec_idx(vec_idx),
`ifdef BIST_GOLDEN_CMP_EN
    .golden(golden), .pass(pass),
`endif
    .signature(signature)
  );

  // c17: dut_in = {N7,N6,N3,N2,N1}, response = {N23,N22}
  function automatic logic [1:0] c17(input logic [4:0] v, input logic f);
    logic n10, n11, n16, n19, n22, n23;
    n10 = ~(v[0] & v[2]);
    n11 = ~(v[2] & v[3]);
    n16 = ~(v[1] & n11);
    n19 = ~(n11 & v[4]);
    n22 = f ? 1'b0 : ~(n10 & n16);
    n23 = ~(n16 & n19);
    return {n23, n22};
  endfunction

  function automatic logic [1:0] resp(input int v);
    case (rsel)
      0:       return 2'b00;
      1:       return c17(5'(v), fault);
      default: return lut[v];
    endcase
  endfunction

  always_comb dut_out = resp(int'(dut_in));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: vector list from the pattern rules, signature by plain arithmetic.
  task automatic model(input logic m, output int nvec, output int sig);
    int v;
    vecs.delete();
    nvec = m ? NV - 1 : NV;
    v = m ? 1 : 0;
    for (int i = 0; i < nvec; i++) begin
      vecs.push_back(v);
      if (m) v = ((v * 2) + ($countones(v & TAPS) % 2)) % NV;
      else   v = v + 1;
    end
    sig = 0;
    foreach (vecs[i]) begin
      sig = ((sig * 2) % 65536) ^ (((sig >> 15) & 1) != 0 ? POLY : 0) ^ int'(resp(vecs[i]));
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic m, input bit noise, output logic [15:0] got);
    int nvec, esig;
    logic [NV-1:0] seen;
    model(m, nvec, esig);
    obs.delete();
    seen = '0;
    mode = m; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      for (int h = 0; h < H; h++) begin
        chk("dut_in", 32'(dut_in), 32'(vecs[i]));
        chk("busy", 32'(busy), 32'd1);
        chk("done_in_run", 32'(done), 32'd0);
        chk("vec_idx", 32'(vec_idx), 32'(i));
        if (h == 0) obs.push_back(int'(dut_in));
        seen[dut_in] = 1'b1;
        if (noise) begin
          start = 1'($urandom_range(1));
          mode  = 1'($urandom_range(1));
        end
        step();
      end
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("dut_in_end", 32'(dut_in), 32'd0);
    chk("vec_idx_end", 32'(vec_idx), 32'(nvec));
    chk("signature", 32'(signature), 32'(esig));
    chk("distinct", 32'($countones(seen)), 32'(nvec));
    start = noise;       // start during done must be ignored
    step();
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sig_hold", 32'(signature), 32'(esig));
`ifdef BIST_GOLDEN_CMP_EN
    chk("pass", 32'(pass), 32'(esig == int'(golden)));
`endif
    got = signature;
  endtask

  initial begin
    logic [15:0] s1, s2, sf;
    int dummy, gsig;
    bit hit;

    // reset with start held high
    rst_n = 1'b0; start = 1'b1;
    repeat (3) step();
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec_idx", 32'(vec_idx), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    start = 1'b0; rst_n = 1'b1;
    step();

    // exhaustive, response tied 0
    rsel = 0;
    run(1'b0, 1'b0, s1);
    chk("exh_zero_sig", 32'(s1), 32'h0);

    // LFSR sequence
    run(1'b1, 1'b0, s1);
    chk("lfsr_v0", 32'(obs[0]), 32'd1);
    chk("lfsr_v1", 32'(obs[1]), 32'd2);
    chk("lfsr_v2", 32'(obs[2]), 32'd4);
    chk("lfsr_v3", 32'(obs[3]), 32'd9);
    chk("lfsr_v4", 32'(obs[4]), 32'd18);
    chk("lfsr_v5", 32'(obs[5]), 32'd5);

    // c17 good x2, then N22 stuck-at-0
    rsel = 1; fault = 1'b0;
    model(1'b0, dummy, gsig);
`ifdef BIST_GOLDEN_CMP_EN
    golden = 16'(gsig);
`endif
    run(1'b0, 1'b0, s1);
    run(1'b0, 1'b0, s2);
    chk("c17_repeat", 32'(s2), 32'(s1));
    chk("c17_nonzero", 32'(s1 != 16'h0), 32'd1);
    fault = 1'b1;
    run(1'b0, 1'b0, sf);
    chk("c17_fault_differs", 32'(sf != s1), 32'd1);
    fault = 1'b0;

    // reset in the middle of a run
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (vec_idx == 10) hit = 1'b1;
      else step();
    end
    chk("midrst_reach", 32'(hit), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dut_in", 32'(dut_in), 32'd0);
    chk("midrst_sig", 32'(signature), 32'd0);
    chk("midrst_vec_idx", 32'(vec_idx), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    run(1'b0, 1'b0, s1);

    // randomized responses, modes, start/mode noise during the run
    for (int r = 0; r < 6; r++) begin
      rsel = 2;
      for (int k = 0; k < NV; k++) lut[k] = 2'($urandom_range(3));
`ifdef BIST_GOLDEN_CMP_EN
      golden = 16'($urandom);
`endif
      repeat ($urandom_range(3)) step();
      run(1'($urandom_range(1)), 1'b1, s1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
